tp_snd_irq_gen: RTL and testbench
=================================

Name: tp_snd_irq_gen

Overview:
Generates the sound Z80 maskable interrupt request (n_irq) from the CPU-board irq_trigger line. It sits directly upstream of the sound CPU INT_n input, in place of the bare n_irq flop. It adds rising-edge qualification on the 3.072 MHz enable, a no-acknowledge timeout, a re-arm holdoff, and a pending latch. The whole block is cleared by the Z80 interrupt acknowledge (irq_clr), so every acknowledge returns it to idle.

Parameters:
TIMEOUT_CEN, 4096, number of cen_3m ticks n_irq may stay low without acknowledge before auto-release (~1.33 ms).
HOLDOFF_CEN, 64, cen_3m ticks after a timeout release before a new request may assert.
CNT_W, 13, counter width; must hold max(TIMEOUT_CEN, HOLDOFF_CEN).

Ports:
clk_49m  in  1  system clock, 49.152 MHz
irq_clr  in  1  asynchronous active-high reset; asserted by system reset or Z80 IORQ&M1 acknowledge
cen_3m  in  1  clock enable, 1 clk_49m cycle in 16 (3.072 MHz)
irq_trigger  in  1  interrupt request level from CPU board, synchronous to clk_49m
n_irq  out  1  active-low Z80 INT
irq_pending  out  1  a trigger edge was seen while a request was outstanding or in holdoff
timed_out  out  1  sticky; a request was auto-released since the last irq_clr
state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset: irq_clr is asynchronous, active-high; clock is clk_49m. While irq_clr is high: state=IDLE, n_irq=1, irq_pending=0, timed_out=0, cnt=0, trig_prev=1.
- trig_prev resets to 1 so that a trigger still high across an acknowledge does not re-fire. A fresh low-to-high transition is required.
- All sampling and counting happens only on clk_49m edges with cen_3m=1. Cycles without cen_3m hold all state.
- edge = cen_3m & irq_trigger & ~trig_prev. trig_prev <= irq_trigger on every cen_3m.
- FSM states (state_dbg encoding): IDLE=0, ASSERT=1, HOLDOFF=2. Encoding 3 is unused; an illegal state returns to IDLE on the next clock.
- IDLE: on edge, go to ASSERT with cnt=0. n_irq goes low on the same clk_49m edge that samples the trigger, so latency is 1 clk_49m after the qualifying cen_3m cycle.
- ASSERT: n_irq=0. cnt increments each cen_3m.
  - An edge in this state sets irq_pending.
  - When cnt reaches TIMEOUT_CEN-1 on a cen_3m cycle: go to HOLDOFF, cnt=0, n_irq=1, timed_out=1.
  - Normal exit is via irq_clr only.
- HOLDOFF: n_irq=1. cnt increments each cen_3m. An edge sets irq_pending.
  - When cnt reaches HOLDOFF_CEN-1: if irq_pending (or an edge occurs in that same cycle), go to ASSERT, clear irq_pending, cnt=0. Otherwise go to IDLE.
- Simultaneous events:
  - irq_clr overrides everything.
  - An edge coinciding with the timeout expiry sets irq_pending.
  - An edge coinciding with the end of holdoff re-asserts immediately.
- irq_clr deasserting mid-cen period: the first clock with irq_clr low and cen_3m=1 may detect an edge only if irq_trigger was low on a prior cen_3m sample.
- Counter arithmetic: unsigned CNT_W; comparisons use the parameter minus 1. The counter never wraps, because each state exits before overflow.
- n_irq and irq_pending are registered outputs, free of glitches from combinational paths.

Decomposition:
- Package tp_snd_pkg:
  - typedef enum logic [1:0] irq_state_t {IDLE, ASSERT, HOLDOFF}
  - localparam CEN3M_DIV=16
  - default TIMEOUT/HOLDOFF constants
- Sub-module tp_cen_edge: cen-qualified rising-edge detector, with its reset value a parameter (INIT=1). It is reusable for the cs_sounddata strobe qualification. The FSM and counter stay in the top module.

Test Plan:
1. irq_clr pulse; trigger 0->1 sampled on a cen_3m cycle -> n_irq=0 one clk_49m later; state_dbg=1; irq_pending=0.
2. From ASSERT, pulse irq_clr for 1 clk with irq_trigger held 1 -> n_irq=1 asynchronously. No reassert over the next 64 cen_3m ticks while irq_trigger stays 1. A 1->0->1 toggle then reasserts.
3. Assert with no acknowledge -> n_irq stays 0 for exactly 4096 cen_3m ticks (65536 clk_49m), then rises; timed_out=1; state_dbg=2.
4. During HOLDOFF, give a trigger edge at tick 10 -> irq_pending=1. At holdoff tick 63, n_irq=0 and irq_pending=0.
5. Timeout with no further edges -> after 64 holdoff ticks state_dbg=0; n_irq stays 1; timed_out stays 1 until irq_clr.
6. Trigger edge on a clock with cen_3m=0 that falls back before the next cen_3m -> no n_irq assertion (edge missed by design).

Source files
------------

// File: rtl/tp_snd_pkg.sv
// Shared types and constants for the sound-CPU interrupt request path.
//   irq_state_t      : request FSM state, also exported on state_dbg
//   CEN3M_DIV        : clk_49m cycles per cen_3m pulse
//   *_DEF constants  : default timeout/holdoff lengths and counter width
package tp_snd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  localparam int unsigned CEN3M_DIV       = 16;
  localparam int unsigned TIMEOUT_CEN_DEF = 4096;  // ~1.33 ms at 3.072 MHz
  localparam int unsigned HOLDOFF_CEN_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 13;

endpackage

// File: rtl/tp_cen_edge.sv
// Clock-enable qualified rising-edge detector.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, loads the history flop with INIT
//   cen_i  : clock enable; history only advances when high
//   d_i    : level to watch, synchronous to clk_i
//   rise_o : high on a cen_i cycle where d_i is 1 and the previous enabled sample was 0
module tp_cen_edge #(
  parameter bit INIT = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cen_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = cen_i ? d_i : prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= INIT;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = cen_i & d_i & ~prev_q;

endmodule

// File: rtl/tp_snd_irq_gen.sv
// Sound Z80 maskable interrupt generator. Qualifies irq_trigger rising edges on cen_3m,
// drives INT_n low until acknowledge, auto-releases after a no-acknowledge timeout,
// then enforces a holdoff during which further edges are latched as pending.
//   clk_49m     : 49.152 MHz system clock
//   irq_clr     : asynchronous active-high clear (system reset or IORQ&M1 acknowledge)
//   cen_3m      : 3.072 MHz clock enable, one clk_49m in 16
//   irq_trigger : request level from the CPU board
//   n_irq       : active-low Z80 INT (registered)
//   irq_pending : an edge arrived while a request was outstanding or in holdoff
//   timed_out   : sticky, a request was auto-released since the last irq_clr
//   state_dbg   : current FSM state encoding
module tp_snd_irq_gen
  import tp_snd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CEN = TIMEOUT_CEN_DEF,
  parameter int unsigned HOLDOFF_CEN = HOLDOFF_CEN_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk_49m,
  input  logic       irq_clr,
  input  logic       cen_3m,
  input  logic       irq_trigger,
  output logic       n_irq,
  output logic       irq_pending,
  output logic       timed_out,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CEN - 1);
  localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CEN - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  irq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             n_irq_q, n_irq_d;
  logic             pending_q, pending_d;
  logic             timed_out_q, timed_out_d;
  logic             rise;

  // History resets high: a trigger still high across an acknowledge must not re-fire.
  tp_cen_edge #(
    .INIT(1'b1)
  ) u_trig_edge (
    .clk_i (clk_49m),
    .rst_i (irq_clr),
    .cen_i (cen_3m),
    .d_i   (irq_trigger),
    .rise_o(rise)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_irq_d     = n_irq_q;
    pending_d   = pending_q;
    timed_out_d = timed_out_q;

    case (state_q)
      IDLE: begin
        n_irq_d = 1'b1;
        cnt_d   = '0;
        if (rise) begin
          state_d = ASSERT;
          n_irq_d = 1'b0;
        end
      end

      ASSERT: begin
        if (cen_3m) begin
          if (rise) begin
            pending_d = 1'b1;
          end
          if (cnt_q == TimeoutLast) begin
            state_d     = HOLDOFF;
            cnt_d       = '0;
            n_irq_d     = 1'b1;
            timed_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      HOLDOFF: begin
        if (cen_3m) begin
          if (cnt_q == HoldoffLast) begin
            cnt_d = '0;
            // An edge landing on the final holdoff tick counts as pending.
            if (pending_q || rise) begin
              state_d   = ASSERT;
              pending_d = 1'b0;
              n_irq_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
            if (rise) begin
              pending_d = 1'b1;
            end
          end
        end
      end

      // Unused encoding recovers on the next clock regardless of cen_3m.
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        n_irq_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_49m or posedge irq_clr) begin
    if (irq_clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_irq_q     <= 1'b1;
      pending_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_irq_q     <= n_irq_d;
      pending_q   <= pending_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign n_irq       = n_irq_q;
  assign irq_pending = pending_q;
  assign timed_out   = timed_out_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_tp_snd_irq_gen.sv
module tb_tp_snd_irq_gen;
  import tp_snd_pkg::*;

  localparam int TO  = int'(TIMEOUT_CEN_DEF);
  localparam int HO  = int'(HOLDOFF_CEN_DEF);
  localparam int DIV = int'(CEN3M_DIV);

  logic       clk_49m = 1'b0;
  logic       irq_clr;
  logic       cen_3m;
  logic       irq_trigger;
  logic       n_irq;
  logic       irq_pending;
  logic       timed_out;
  logic [1:0] state_dbg;

  always #5 clk_49m = ~clk_49m;

  tp_snd_irq_gen dut (
    .clk_49m    (clk_49m),
    .irq_clr    (irq_clr),
    .cen_3m     (cen_3m),
    .irq_trigger(irq_trigger),
    .n_irq      (n_irq),
    .irq_pending(irq_pending),
    .timed_out  (timed_out),
    .state_dbg  (state_dbg)
  );

  int tests_run;
  int tests_failed;

  // Reference model: mode 0 idle, 1 requesting, 2 holdoff; ticks counts enabled
  // ticks spent in the current mode (1 after the first tick).
  int m_mode;
  int m_ticks;
  bit m_prev;
  bit m_pend;
  bit m_to;

  int cen_div;  // 0 = random enable, otherwise one enable every cen_div clocks
  int phase;

  function automatic logic [4:0] exp_vec();
    logic [1:0] st;
    st = m_mode[1:0];
    return {(m_mode != 1), m_pend, m_to, st};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {n_irq, irq_pending, timed_out, state_dbg};
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_ticks = 0;
    m_prev  = 1'b1;
    m_pend  = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_tick(input bit t);
    bit rise;
    rise   = t && !m_prev;
    m_prev = t;
    case (m_mode)
      0: if (rise) begin
        m_mode  = 1;
        m_ticks = 0;
      end
      1: begin
        m_ticks++;
        if (rise) m_pend = 1'b1;
        if (m_ticks == TO) begin
          m_mode  = 2;
          m_ticks = 0;
          m_to    = 1'b1;
        end
      end
      default: begin
        m_ticks++;
        if (rise) m_pend = 1'b1;
        if (m_ticks == HO) begin
          m_mode  = m_pend ? 1 : 0;
          m_pend  = 1'b0;
          m_ticks = 0;
        end
      end
    endcase
  endtask

  // One clk_49m cycle: drive at the falling edge, model at the rising edge, return at
  // the next falling edge where outputs are sampled.
  task automatic step(input logic t);
    logic c;
    if (cen_div == 0) begin
      c = ($urandom_range(0, 3) == 0);
    end else begin
      c     = (phase == 0);
      phase = (phase + 1) % cen_div;
    end
    cen_3m      = c;
    irq_trigger = t;
    @(posedge clk_49m);
    if (c) model_tick(t);
    @(negedge clk_49m);
  endtask

  task automatic do_clr();
    irq_clr = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL clr_async: got %b want %b", obs_vec(), exp_vec());
    end
    @(posedge clk_49m);
    @(negedge clk_49m);
    irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    irq_clr     = 1'b1;
    cen_3m      = 1'b0;
    irq_trigger = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_49m);
    tests_run++;
    if (obs_vec() !== 5'b1_0_0_00) begin
      tests_failed++;
      $display("FAIL reset_state: got %b want %b", obs_vec(), 5'b1_0_0_00);
    end
    irq_clr = 1'b0;
  endtask

  task automatic test_assert_latency();
    bit done;
    cen_div = DIV;
    phase   = 1;
    repeat (DIV) step(1'b0);
    done = 1'b0;
    for (int i = 0; i < DIV && !done; i++) begin
      step(1'b1);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL latency_step%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (cen_3m) done = 1'b1;
    end
    tests_run++;
    if ({n_irq, irq_pending, state_dbg} !== 4'b0_0_01) begin
      tests_failed++;
      $display("FAIL latency_assert: got %b want %b", {n_irq, irq_pending, state_dbg}, 4'b0001);
    end
  endtask

  task automatic test_ack_no_refire();
    do_clr();
    for (int i = 0; i < HO * DIV; i++) begin
      step(1'b1);
      tests_run++;
      if (n_irq !== 1'b1 || obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL no_refire_%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    repeat (DIV) step(1'b0);
    repeat (DIV) step(1'b1);
    tests_run++;
    if (n_irq !== 1'b0 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL toggle_reassert: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  // Enable every other clock: the timeout depends only on the tick count.
  task automatic test_timeout();
    int guard;
    int lowcnt;
    do_clr();
    cen_div = 2;
    phase   = 0;
    repeat (4) step(1'b0);
    guard = 0;
    while (m_mode != 1 && guard < 4) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if (n_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_start: got n_irq=%b want 0", n_irq);
    end
    lowcnt = 1;
    guard  = 0;
    while (n_irq === 1'b0 && guard < 4 * TO * 2) begin
      step(1'b1);
      guard++;
      if (n_irq === 1'b0) lowcnt++;
    end
    tests_run++;
    if (lowcnt != TO * 2) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d clocks low want %0d", lowcnt, TO * 2);
    end
    tests_run++;
    if (obs_vec() !== exp_vec() || {timed_out, state_dbg} !== 3'b1_10) begin
      tests_failed++;
      $display("FAIL timeout_state: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_holdoff_pending();
    int guard;
    guard = 0;
    while (m_ticks < 9 && guard < 100) begin
      step(1'b0);
      guard++;
    end
    while (m_ticks < 10 && guard < 100) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if (irq_pending !== 1'b1 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL holdoff_pending: got %b want %b", obs_vec(), exp_vec());
    end
    guard = 0;
    while (m_mode == 2 && guard < 4 * HO) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if ({n_irq, irq_pending, state_dbg} !== 4'b0_0_01 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL holdoff_reassert: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_holdoff_idle();
    int guard;
    cen_div = 1;
    phase   = 0;
    guard   = 0;
    while (m_mode == 1 && guard < TO + 10) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if (state_dbg !== 2'd2 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL idle_timeout: got %b want %b", obs_vec(), exp_vec());
    end
    guard = 0;
    while (m_mode == 2 && guard < HO + 10) begin
      step(1'b1);
      guard++;
    end
    repeat (20) step(1'b1);
    tests_run++;
    if ({n_irq, timed_out, state_dbg} !== 4'b1_1_00 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL idle_after_holdoff: got %b want %b", obs_vec(), exp_vec());
    end
    do_clr();
    tests_run++;
    if (timed_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL timed_out_clear: got %b want 0", timed_out);
    end
  endtask

  task automatic test_expiry_edges();
    int guard;
    cen_div = 1;
    phase   = 0;
    step(1'b0);
    step(1'b1);
    guard = 0;
    while (m_ticks < TO - 1 && guard < TO + 10) begin
      step(1'b0);
      guard++;
    end
    step(1'b1);
    tests_run++;
    if ({irq_pending, timed_out, state_dbg} !== 4'b1_1_10 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL edge_at_expiry: got %b want %b", obs_vec(), exp_vec());
    end
    guard = 0;
    while (m_mode == 2 && guard < HO + 10) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if ({n_irq, irq_pending, state_dbg} !== 4'b0_0_01 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL expiry_reassert: got %b want %b", obs_vec(), exp_vec());
    end
    guard = 0;
    while (m_mode == 1 && guard < TO + 10) begin
      step(1'b0);
      guard++;
    end
    while (m_ticks < HO - 1 && guard < TO + HO + 20) begin
      step(1'b0);
      guard++;
    end
    step(1'b1);
    tests_run++;
    if ({n_irq, irq_pending, state_dbg} !== 4'b0_0_01 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL edge_at_holdoff_end: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_missed_edge();
    do_clr();
    cen_div = DIV;
    phase   = 0;
    repeat (DIV) step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (DIV - 2) step(1'b0);
    repeat (2 * DIV) step(1'b0);
    tests_run++;
    if ({n_irq, state_dbg} !== 3'b1_00 || obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL missed_edge: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic t;
    cen_div = 0;
    t = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_clr();
      end
      if ($urandom_range(0, 2) == 0) t = ~t;
      step(t);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cen_div      = DIV;
    phase        = 0;
    @(negedge clk_49m);
    test_reset();
    test_assert_latency();
    test_ack_no_refire();
    test_timeout();
    test_holdoff_pending();
    test_holdoff_idle();
    test_expiry_edges();
    test_missed_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
